// File: rtl/bitty_alu_seq_if.sv
// Operand/result bundle for bitty_alu_seq: request side driven by the control
// FSM (master), response side driven by the ALU (slave).
interface bitty_alu_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [3:0]       select;
  logic             carry_in;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] alu_out;
  logic             carry_out;
  logic             zero;
  logic             compare;

  modport master (
    output start, select, carry_in, in_a, in_b,
    input  busy, done, alu_out, carry_out, zero, compare
  );

  modport slave (
    input  start, select, carry_in, in_a, in_b,
    output busy, done, alu_out, carry_out, zero, compare
  );
endinterface

// File: rtl/bitty_alu_seq.sv
// Clocked BittyPro ALU: latches operands on start, executes single-cycle ops
// in one EXEC cycle and multiplies with an iterative shift-add loop.
module bitty_alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic            clk,
  input  logic            reset,
  bitty_alu_seq_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, EXEC, MUL} state_e;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_SUB = 4'd1, OP_INC = 4'd2, OP_DEC = 4'd3,
    OP_AND = 4'd4, OP_OR  = 4'd5, OP_XOR = 4'd6, OP_NOT = 4'd7,
    OP_SHL = 4'd8, OP_SHR = 4'd9, OP_MUL = 4'd10
  } op_e;

  state_e             state_q, state_d;
  op_e                sel_q, sel_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic               cin_q, cin_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic               carry_q, carry_d, zero_q, zero_d, cmp_q, cmp_d;
  logic               busy_q, busy_d, done_q, done_d;

  logic [WIDTH:0]     wide;
  logic [WIDTH-1:0]   ex_res;
  logic               ex_c;

  // Single-cycle datapath on the latched operands; arithmetic at WIDTH+1 bits.
  always_comb begin
    wide   = '0;
    ex_res = '0;
    ex_c   = 1'b0;
    case (sel_q)
      OP_ADD: begin
        wide   = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
        ex_res = wide[WIDTH-1:0];
        ex_c   = wide[WIDTH];
      end
      OP_SUB: begin
        // Bit WIDTH of the extended difference is the borrow (a < b + cin).
        wide   = {1'b0, a_q} - {1'b0, b_q} - {{WIDTH{1'b0}}, cin_q};
        ex_res = wide[WIDTH-1:0];
        ex_c   = wide[WIDTH];
      end
      OP_INC: begin
        wide   = {1'b0, a_q} + {{WIDTH{1'b0}}, 1'b1};
        ex_res = wide[WIDTH-1:0];
        ex_c   = wide[WIDTH];
      end
      OP_DEC: begin
        ex_res = a_q - {{(WIDTH-1){1'b0}}, 1'b1};
        ex_c   = (a_q == '0);
      end
      OP_AND: ex_res = a_q & b_q;
      OP_OR:  ex_res = a_q | b_q;
      OP_XOR: ex_res = a_q ^ b_q;
      OP_NOT: ex_res = ~a_q;
      OP_SHL: begin
        ex_res = {a_q[WIDTH-2:0], cin_q};
        ex_c   = a_q[WIDTH-1];
      end
      OP_SHR: begin
        ex_res = {cin_q, a_q[WIDTH-1:1]};
        ex_c   = a_q[0];
      end
      default: begin
        ex_res = '0;
        ex_c   = 1'b0;
      end
    endcase
  end

  // Control FSM next-state, operand latching, multiplier step and result update.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    a_d      = a_q;
    b_d      = b_q;
    cin_d    = cin_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    cmp_d    = cmp_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d    = bus.in_a;
          b_d    = bus.in_b;
          cin_d  = bus.carry_in;
          sel_d  = op_e'(bus.select);
          busy_d = 1'b1;
          if (bus.select == 4'd10) begin
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, bus.in_a};
            mplier_d = bus.in_b;
            cnt_d    = CW'(WIDTH);
            state_d  = MUL;
          end else begin
            state_d  = EXEC;
          end
        end
      end
      EXEC: begin
        out_d   = ex_res;
        carry_d = ex_c;
        zero_d  = (ex_res == '0);
        cmp_d   = (a_q == b_q);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      MUL: begin
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
        // Last iteration: the result is taken from this cycle's accumulation.
        if (cnt_q == CW'(1)) begin
          out_d   = acc_d[WIDTH-1:0];
          carry_d = |acc_d[2*WIDTH-1:WIDTH];
          zero_d  = (acc_d[WIDTH-1:0] == '0);
          cmp_d   = (a_q == b_q);
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      sel_q    <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      cmp_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cin_q    <= cin_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      cmp_q    <= cmp_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.alu_out   = out_q;
  assign bus.carry_out = carry_q;
  assign bus.zero      = zero_q;
  assign bus.compare   = cmp_q;
endmodule

// File: tb/tb_bitty_alu_seq.sv
// Scoreboard bench for bitty_alu_seq (WIDTH=16): directed ops push expected
// results; a negedge monitor pops and checks on every done pulse.
module tb_bitty_alu_seq;
  localparam int W = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bitty_alu_seq_if #(.WIDTH(W)) bus ();
  bitty_alu_seq #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    string       name;
    logic [W-1:0] out;
    logic        c;
    logic        z;
    logic        m;
    int unsigned t0;
    int unsigned lat;
  } exp_t;

  exp_t        sbq[$];
  int unsigned cyc   = 0;
  int unsigned tests = 0;
  int unsigned fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: counts negedges and checks each done pulse against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.done === 1'b1) begin
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pending op", cyc);
        end else begin
          e = sbq.pop_front();
          chk({e.name, ".alu_out"},   64'(bus.alu_out),   64'(e.out));
          chk({e.name, ".carry_out"}, 64'(bus.carry_out), 64'(e.c));
          chk({e.name, ".zero"},      64'(bus.zero),      64'(e.z));
          chk({e.name, ".compare"},   64'(bus.compare),   64'(e.m));
          chk({e.name, ".latency"},   64'(cyc - e.t0),    64'(e.lat + 1));
          chk({e.name, ".busy"},      64'(bus.busy),      64'(0));
        end
      end
    end
  end

  // Drives one request starting just after the current negedge; start is held
  // across exactly one rising edge.
  task automatic issue(input logic [3:0] sel, input logic cin, input logic [W-1:0] a,
                       input logic [W-1:0] b, input bit push, input string name,
                       input logic [W-1:0] eo, input logic ec, input logic ez, input logic em);
    exp_t e;
    #1;
    bus.start    = 1'b1;
    bus.select   = sel;
    bus.carry_in = cin;
    bus.in_a     = a;
    bus.in_b     = b;
    if (push) begin
      e.name = name; e.out = eo; e.c = ec; e.z = ez; e.m = em;
      e.t0   = cyc;
      e.lat  = (sel == 4'd10) ? W : 1;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
  endtask

  // Returns at the negedge where done is seen, bounded to 40 cycles.
  task automatic wait_done(input string name);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) return;
    end
    tests++;
    fails++;
    $display("FAIL %s.timeout: got no done in 40 cycles expected done", name);
  endtask

  initial begin
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.select   = '0;
    bus.carry_in = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;

    // Start while reset is held must not produce a done.
    repeat (2) @(negedge clk);
    #1;
    bus.start = 1'b1; bus.select = 4'd0; bus.in_a = 16'hFFFF; bus.in_b = 16'h0001;
    repeat (3) @(posedge clk);
    #1;
    bus.start = 1'b0;
    reset     = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst.busy",      64'(bus.busy),      64'(0));
    chk("rst.done",      64'(bus.done),      64'(0));
    chk("rst.alu_out",   64'(bus.alu_out),   64'(0));
    chk("rst.carry_out", 64'(bus.carry_out), 64'(0));
    chk("rst.zero",      64'(bus.zero),      64'(0));
    chk("rst.compare",   64'(bus.compare),   64'(0));

    // Each op after the first is issued in the done cycle of the previous one.
    issue(4'd0, 1'b0, 16'hFFFF, 16'h0001, 1, "add_wrap", 16'h0000, 1'b1, 1'b1, 1'b0);
    wait_done("add_wrap");
    issue(4'd1, 1'b1, 16'h0005, 16'h0005, 1, "sub_borrow", 16'hFFFF, 1'b1, 1'b0, 1'b1);
    wait_done("sub_borrow");
    issue(4'd1, 1'b0, 16'h0010, 16'h0003, 1, "sub_plain", 16'h000D, 1'b0, 1'b0, 1'b0);
    wait_done("sub_plain");
    issue(4'd10, 1'b0, 16'h0100, 16'h0100, 1, "mul_ovf", 16'h0000, 1'b1, 1'b1, 1'b1);
    wait_done("mul_ovf");
    issue(4'd10, 1'b1, 16'h0012, 16'h0034, 1, "mul_small", 16'h03A8, 1'b0, 1'b0, 1'b0);
    wait_done("mul_small");
    issue(4'd10, 1'b0, 16'hFFFF, 16'hFFFF, 1, "mul_max", 16'h0001, 1'b1, 1'b0, 1'b1);
    wait_done("mul_max");

    // Start pulsed mid-multiply is ignored.
    issue(4'd10, 1'b0, 16'h0003, 16'h0005, 1, "mul_ign", 16'h000F, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("mul_ign.busy_mid", 64'(bus.busy), 64'(1));
    issue(4'd0, 1'b0, 16'h0001, 16'h0001, 0, "ignored_add", '0, 1'b0, 1'b0, 1'b0);
    wait_done("mul_ign");
    issue(4'd0, 1'b1, 16'h1234, 16'h1111, 1, "add_b2b", 16'h2346, 1'b0, 1'b0, 1'b0);
    wait_done("add_b2b");
    issue(4'd6, 1'b0, 16'hF0F0, 16'hF0F0, 1, "xor_eq", 16'h0000, 1'b0, 1'b1, 1'b1);
    wait_done("xor_eq");
    issue(4'd2, 1'b0, 16'hFFFF, 16'h0000, 1, "inc_wrap", 16'h0000, 1'b1, 1'b1, 1'b0);
    wait_done("inc_wrap");
    issue(4'd4, 1'b0, 16'hF0F0, 16'h0FF0, 1, "and", 16'h00F0, 1'b0, 1'b0, 1'b0);
    wait_done("and");
    issue(4'd5, 1'b1, 16'hF0F0, 16'h0FF0, 1, "or", 16'hFFF0, 1'b0, 1'b0, 1'b0);
    wait_done("or");
    issue(4'd7, 1'b0, 16'h00FF, 16'h0000, 1, "not", 16'hFF00, 1'b0, 1'b0, 1'b0);
    wait_done("not");
    issue(4'd9, 1'b1, 16'h0001, 16'h0000, 1, "shr", 16'h8000, 1'b1, 1'b0, 1'b0);
    wait_done("shr");
    issue(4'd12, 1'b1, 16'h0005, 16'h0005, 1, "op12", 16'h0000, 1'b0, 1'b1, 1'b1);
    wait_done("op12");
    issue(4'd3, 1'b0, 16'h0000, 16'h0001, 1, "dec_zero", 16'hFFFF, 1'b1, 1'b0, 1'b0);
    wait_done("dec_zero");

    // Reset during a multiply aborts it without a done pulse.
    issue(4'd10, 1'b0, 16'h0007, 16'h0009, 0, "mul_abort", '0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort.busy",      64'(bus.busy),      64'(0));
    chk("abort.alu_out",   64'(bus.alu_out),   64'(0));
    chk("abort.carry_out", 64'(bus.carry_out), 64'(0));
    chk("abort.zero",      64'(bus.zero),      64'(0));
    repeat (20) @(negedge clk);
    issue(4'd8, 1'b1, 16'h8001, 16'h0000, 1, "shl", 16'h0003, 1'b1, 1'b0, 1'b0);
    wait_done("shl");

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 64'(sbq.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
